// File: rtl/formant_smoother_if.sv
// Frame-in / smoothed-frame-out bundle for formant_smoother.
//   master: drives formant_valid/formant_freq, observes the smoothed results.
//   slave : the smoother itself.
// Signals:
//   formant_valid  one-cycle frame strobe
//   formant_freq   FORMANTS x BIT_WIDTH unsigned estimates
//   smooth_valid   one-cycle strobe, smooth_freq updated in the same cycle
//   smooth_freq    averaged frequencies, held between strobes
//   frames_seen    accepted frames, saturating at DEPTH
//   busy           frame in flight
//   dropped        one-cycle pulse when a frame is rejected
interface formant_smoother_if #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned FORMANTS  = 5,
  parameter int unsigned DEPTH     = 4
);
  logic                                formant_valid;
  logic [0:FORMANTS-1][BIT_WIDTH-1:0]  formant_freq;
  logic                                smooth_valid;
  logic [0:FORMANTS-1][BIT_WIDTH-1:0]  smooth_freq;
  logic [$clog2(DEPTH):0]              frames_seen;
  logic                                busy;
  logic                                dropped;

  modport master (
    output formant_valid, formant_freq,
    input  smooth_valid, smooth_freq, frames_seen, busy, dropped
  );

  modport slave (
    input  formant_valid, formant_freq,
    output smooth_valid, smooth_freq, frames_seen, busy, dropped
  );
endinterface

// File: rtl/formant_smoother.sv
// Per-formant moving average over the last DEPTH accepted frames.
// A frame is captured in IDLE, then one formant per cycle is folded into a running
// sum (one shared add/sub) and written to a DEPTH x FORMANTS history store; the
// averaged frame is emitted with a one-cycle smooth_valid strobe.
// Ports:
//   clk_in  rising-edge clock
//   rst_in  synchronous active-high reset
//   bus     formant_smoother_if.slave (frame in, smoothed frame and status out)
// Optional feature: define FORMANT_CLAMP_EN to slew-limit each incoming value to
// +/-MAX_STEP around the previous output (once at least one frame has been seen).
module formant_smoother #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned FORMANTS  = 5,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_STEP  = 64
) (
  input logic               clk_in,
  input logic               rst_in,
  formant_smoother_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned FsW  = PtrW + 1;
  localparam int unsigned SumW = BIT_WIDTH + PtrW;
  localparam int unsigned IdxW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FORMANTS - 1);
  localparam logic [FsW-1:0]  FullCnt = FsW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StProc, StOut} state_e;

  state_e                             state_q, state_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic [PtrW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [FsW-1:0]                     frames_seen_q, frames_seen_d, frames_next;
  logic [0:FORMANTS-1][BIT_WIDTH-1:0] cap_q, cap_d;
  logic [0:FORMANTS-1][BIT_WIDTH-1:0] smooth_q, smooth_d;
  logic [SumW-1:0]                    sum_q [FORMANTS];
  logic [SumW-1:0]                    sum_d [FORMANTS];
  logic                               smooth_valid_q, smooth_valid_d;
  logic                               busy_q, busy_d;
  logic                               dropped_q, dropped_d;

  // History is never reset: stale entries are only read once frames_seen is full,
  // by which point every slot has been rewritten since the last reset.
  logic [BIT_WIDTH-1:0] hist_q [DEPTH][FORMANTS];
  logic                 hist_we;

  logic [BIT_WIDTH-1:0] cap_cur, new_val, old_val;

  assign cap_cur = cap_q[idx_q];

`ifdef FORMANT_CLAMP_EN
  // One extra bit so lo/hi cannot wrap before they are floored/saturated.
  localparam logic [BIT_WIDTH:0] Step   = (BIT_WIDTH + 1)'(MAX_STEP);
  localparam logic [BIT_WIDTH:0] MaxVal = {1'b0, {BIT_WIDTH{1'b1}}};

  logic [BIT_WIDTH:0] prev_w, cap_w, lo_w, hi_w;

  always_comb begin
    prev_w = {1'b0, smooth_q[idx_q]};
    cap_w  = {1'b0, cap_cur};
    lo_w   = (prev_w >= Step) ? prev_w - Step : '0;
    hi_w   = prev_w + Step;
    if (hi_w > MaxVal) hi_w = MaxVal;
    if (frames_seen_q == '0)  new_val = cap_cur;
    else if (cap_w < lo_w)    new_val = lo_w[BIT_WIDTH-1:0];
    else if (cap_w > hi_w)    new_val = hi_w[BIT_WIDTH-1:0];
    else                      new_val = cap_cur;
  end
`else
  assign new_val = cap_cur;
`endif

  assign old_val     = (frames_seen_q == FullCnt) ? hist_q[wr_ptr_q][idx_q] : '0;
  assign frames_next = (frames_seen_q == FullCnt) ? frames_seen_q : frames_seen_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wr_ptr_d       = wr_ptr_q;
    frames_seen_d  = frames_seen_q;
    cap_d          = cap_q;
    smooth_d       = smooth_q;
    sum_d          = sum_q;
    smooth_valid_d = 1'b0;
    busy_d         = busy_q;
    dropped_d      = 1'b0;
    hist_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.formant_valid) begin
          cap_d   = bus.formant_freq;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StProc;
        end
      end
      StProc: begin
        dropped_d    = bus.formant_valid;
        hist_we      = ~rst_in;
        // Capture slot is reused to hold the (possibly clamped) value for warm-up.
        cap_d[idx_q] = new_val;
        sum_d[idx_q] = sum_q[idx_q] - SumW'(old_val) + SumW'(new_val);
        if (idx_q == LastIdx) begin
          // Output is registered here so it is visible during the OUT cycle.
          wr_ptr_d       = wr_ptr_q + 1'b1;
          frames_seen_d  = frames_next;
          smooth_valid_d = 1'b1;
          for (int k = 0; k < FORMANTS; k++) begin
            smooth_d[k] = (frames_next == FullCnt) ? BIT_WIDTH'(sum_d[k] >> PtrW) : cap_d[k];
          end
          state_d = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        dropped_d = bus.formant_valid;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      wr_ptr_q       <= '0;
      frames_seen_q  <= '0;
      cap_q          <= '0;
      smooth_q       <= '0;
      smooth_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      dropped_q      <= 1'b0;
      for (int k = 0; k < FORMANTS; k++) sum_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wr_ptr_q       <= wr_ptr_d;
      frames_seen_q  <= frames_seen_d;
      cap_q          <= cap_d;
      smooth_q       <= smooth_d;
      smooth_valid_q <= smooth_valid_d;
      busy_q         <= busy_d;
      dropped_q      <= dropped_d;
      sum_q          <= sum_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (hist_we) hist_q[wr_ptr_q][idx_q] <= new_val;
  end

  assign bus.smooth_valid = smooth_valid_q;
  assign bus.smooth_freq  = smooth_q;
  assign bus.frames_seen  = frames_seen_q;
  assign bus.busy         = busy_q;
  assign bus.dropped      = dropped_q;
endmodule

// File: tb/tb_formant_smoother.sv
// Randomized self-checking bench for formant_smoother against a windowed-average
// reference model (queue of the last DEPTH frames). Directed frames cover warm-up,
// averaging/floor, dropped frames, mid-frame reset and back-to-back frames.
module tb_formant_smoother;
  localparam int unsigned BW       = 32;
  localparam int unsigned NF       = 5;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_STEP = 64;

  typedef longint frame_t [NF];

  logic   clk_in = 1'b0;
  logic   rst_in = 1'b1;
  int     n_checks = 0;
  int     n_errors = 0;
  frame_t win [$];
  frame_t prev_out;

  formant_smoother_if #(.BIT_WIDTH(BW), .FORMANTS(NF), .DEPTH(DEPTH)) fs_if ();

  formant_smoother #(
    .BIT_WIDTH(BW),
    .FORMANTS (NF),
    .DEPTH    (DEPTH),
    .MAX_STEP (MAX_STEP)
  ) u_dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (fs_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: append the frame to a sliding window, average once the window is full.
  function automatic frame_t model_step(input frame_t in);
    frame_t nv;
    frame_t out;
    longint s;
    for (int k = 0; k < NF; k++) begin
      nv[k] = in[k];
`ifdef FORMANT_CLAMP_EN
      if (win.size() > 0) begin
        longint lo, hi, mx;
        mx = (longint'(1) << BW) - 1;
        lo = prev_out[k] - MAX_STEP;
        if (lo < 0) lo = 0;
        hi = prev_out[k] + MAX_STEP;
        if (hi > mx) hi = mx;
        if (nv[k] < lo) nv[k] = lo;
        if (nv[k] > hi) nv[k] = hi;
      end
`endif
    end
    win.push_back(nv);
    if (win.size() > DEPTH) void'(win.pop_front());
    for (int k = 0; k < NF; k++) begin
      if (win.size() == DEPTH) begin
        s = 0;
        foreach (win[i]) s += win[i][k];
        out[k] = s / DEPTH;
      end else begin
        out[k] = nv[k];
      end
    end
    prev_out = out;
    return out;
  endfunction

  function automatic frame_t rand_frame(input bit wide);
    frame_t f;
    for (int k = 0; k < NF; k++) f[k] = wide ? longint'($urandom()) : longint'($urandom_range(5000));
    return f;
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_sv"}, fs_if.smooth_valid, 0);
    check_val({tag, "_busy"}, fs_if.busy, 0);
    check_val({tag, "_drop"}, fs_if.dropped, 0);
    check_val({tag, "_fs"}, fs_if.frames_seen, 0);
    for (int k = 0; k < NF; k++) check_val($sformatf("%s_f%0d", tag, k), fs_if.smooth_freq[k], 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    fs_if.formant_valid = 1'b0;
    fs_if.formant_freq  = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    win.delete();
    for (int k = 0; k < NF; k++) prev_out[k] = 0;
    check_idle_zero("rst");
  endtask

  // Called and returns at a negedge; the next frame may be driven immediately.
  // drop_at != 0 pulses a junk frame in that cycle of the in-flight frame.
  task automatic run_frame(input frame_t f, input int drop_at);
    frame_t exp_o;
    int     lat;
    exp_o = model_step(f);
    fs_if.formant_valid = 1'b1;
    for (int k = 0; k < NF; k++) fs_if.formant_freq[k] = BW'(f[k]);
    @(negedge clk_in);
    fs_if.formant_valid = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
      check_val("busy", fs_if.busy, 1);
      check_val("dropped", fs_if.dropped, (drop_at != 0 && cyc == drop_at + 1) ? 1 : 0);
      if (fs_if.smooth_valid) lat = cyc;
      fs_if.formant_valid = (cyc == drop_at);
      if (cyc == drop_at) fs_if.formant_freq = {NF{BW'($urandom())}};
      if (lat == 0) @(negedge clk_in);
    end
    fs_if.formant_valid = 1'b0;
    check_val("latency", lat, NF + 1);
    check_val("frames_seen", fs_if.frames_seen, win.size());
    for (int k = 0; k < NF; k++) check_val($sformatf("smooth_f%0d", k), fs_if.smooth_freq[k], exp_o[k]);
    @(negedge clk_in);
    check_val("sv_once", fs_if.smooth_valid, 0);
    check_val("busy_end", fs_if.busy, 0);
    check_val("drop_end", fs_if.dropped, 0);
  endtask

  // Reset asserted in the third PROC cycle; the frame must vanish without a trace.
  task automatic run_abort(input frame_t f);
    fs_if.formant_valid = 1'b1;
    for (int k = 0; k < NF; k++) fs_if.formant_freq[k] = BW'(f[k]);
    @(negedge clk_in);
    fs_if.formant_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    check_val("abort_busy", fs_if.busy, 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    win.delete();
    for (int k = 0; k < NF; k++) prev_out[k] = 0;
    for (int i = 0; i < 8; i++) begin
      check_val("abort_sv", fs_if.smooth_valid, 0);
      @(negedge clk_in);
    end
    check_idle_zero("abort");
  endtask

  initial begin
    frame_t f;
    do_reset();

    f = '{500, 1500, 2500, 3500, 4500};
    run_frame(f, 0);
    check_val("first_f0", fs_if.smooth_freq[0], 500);
    check_val("first_f4", fs_if.smooth_freq[4], 4500);
    check_val("first_fs", fs_if.frames_seen, 1);

    do_reset();
    for (int i = 1; i <= 4; i++) begin
      f = '{400 * i, 100, 200, 300, 400};
      run_frame(f, 0);
    end
`ifndef FORMANT_CLAMP_EN
    check_val("avg4_f0", fs_if.smooth_freq[0], 1000);
    check_val("avg4_fs", fs_if.frames_seen, 4);
`endif
    f = '{2000, 100, 200, 300, 400};
    run_frame(f, 0);
`ifndef FORMANT_CLAMP_EN
    check_val("slide_f0", fs_if.smooth_freq[0], 1400);
`endif
    for (int i = 0; i < 4; i++) begin
      f = '{(i == 3) ? 2 : 1, 7, 7, 7, 9};
      run_frame(f, 0);
    end
`ifndef FORMANT_CLAMP_EN
    check_val("floor_f0", fs_if.smooth_freq[0], 1);
    check_val("floor_f4", fs_if.smooth_freq[4], 9);
`endif

    run_frame(rand_frame(1'b0), 2);
    run_frame(rand_frame(1'b0), 0);

    run_abort(rand_frame(1'b0));
    f = '{700, 800, 900, 1000, 1100};
    run_frame(f, 0);
    check_val("post_abort_f0", fs_if.smooth_freq[0], 700);
    check_val("post_abort_fs", fs_if.frames_seen, 1);

`ifdef FORMANT_CLAMP_EN
    do_reset();
    f = '{1000, 1000, 1000, 1000, 1000};
    repeat (4) run_frame(f, 0);
    f = '{2000, 1000, 1000, 1000, 1000};
    run_frame(f, 0);
    check_val("clamp_hi_f0", fs_if.smooth_freq[0], 1016);
    do_reset();
    f = '{30, 30, 30, 30, 30};
    run_frame(f, 0);
    f = '{0, 30, 30, 30, 30};
    run_frame(f, 0);
    check_val("clamp_lo_f0", fs_if.smooth_freq[0], 0);
`endif

    do_reset();
    for (int i = 0; i < 10; i++) run_frame(rand_frame(1'b0), 0);
    check_val("sat_fs", fs_if.frames_seen, DEPTH);
    for (int i = 0; i < 20; i++) run_frame(rand_frame(i[0]), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
